// File: rtl/sevenseg_capture.sv
// +--------------------------------------------------------------------------+
// | sevenseg_capture                                                         |
// | Recovers hex nibbles from a multiplexed 7-segment bus with debounce.     |
// | Option: SEVENSEG_CAPTURE_ACTIVE_LOW_EN -> active-low segs/selects.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sevenseg_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          seg_in,
    input  logic [NDIG-1:0]     dig_sel,
    output logic [4*NDIG-1:0]   value,
    output logic [NDIG-1:0]     digit_valid,
    output logic                upd,
    output logic [7:0]          upd_idx,
    output logic                err
);

    localparam int         SW         = 7 + NDIG;
    localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYC - 1);
    localparam logic [0:0] ST_WAIT    = 1'b0;
    localparam logic [0:0] ST_HELD    = 1'b1;

    logic [SW-1:0]   sample;
    logic [SW-1:0]   s_q;
    logic [7:0]      cnt;
    logic [0:0]      state;
    logic [6:0]      seg_q;
    logic [NDIG-1:0] sel_q;
    logic            changed;
    logic            accept;
    logic            multi;
    logic            legal;
    logic [3:0]      nibble;
    logic [7:0]      idx;

`ifdef SEVENSEG_CAPTURE_ACTIVE_LOW_EN
    // Common-anode boards: invert before the register so everything downstream is active-high.
    assign sample = ~{seg_in, dig_sel};
`else
    assign sample = {seg_in, dig_sel};
`endif

    assign seg_q   = s_q[SW-1:NDIG];
    assign sel_q   = s_q[NDIG-1:0];
    assign changed = (sample != s_q);
    assign accept  = (state == ST_WAIT) && (cnt == ACCEPT_CNT);
    assign multi   = |(sel_q & (sel_q - 1'b1));

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (seg_q)
            7'h3F: nibble = 4'h0;
            7'h06: nibble = 4'h1;
            7'h5B: nibble = 4'h2;
            7'h4F: nibble = 4'h3;
            7'h66: nibble = 4'h4;
            7'h6D: nibble = 4'h5;
            7'h7D: nibble = 4'h6;
            7'h07: nibble = 4'h7;
            7'h7F: nibble = 4'h8;
            7'h6F: nibble = 4'h9;
            7'h77: nibble = 4'hA;
            7'h7C: nibble = 4'hB;
            7'h39: nibble = 4'hC;
            7'h5E: nibble = 4'hD;
            7'h79: nibble = 4'hE;
            7'h71: nibble = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        idx = 8'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel_q[i]) begin
                idx = 8'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q         <= '0;
            cnt         <= 8'd0;
            state       <= ST_WAIT;
            value       <= '0;
            digit_valid <= '0;
            upd         <= 1'b0;
            upd_idx     <= 8'd0;
            err         <= 1'b0;
        end else begin
            s_q <= sample;
            upd <= 1'b0;
            err <= 1'b0;

            // A changing sample restarts the count but never cancels this edge's acceptance.
            if (changed) begin
                cnt   <= 8'd0;
                state <= ST_WAIT;
            end else begin
                if (cnt != 8'hFF) begin
                    cnt <= cnt + 8'd1;
                end
                if (accept) begin
                    state <= ST_HELD;
                end
            end

            if (accept && (|sel_q)) begin
                if (multi) begin
                    err <= 1'b1;
                end else if (seg_q == 7'h00) begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (sel_q[i]) begin
                            digit_valid[i] <= 1'b0;
                        end
                    end
                end else if (legal) begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (sel_q[i]) begin
                            value[4*i +: 4] <= nibble;
                            digit_valid[i]  <= 1'b1;
                        end
                    end
                    upd     <= 1'b1;
                    upd_idx <= idx;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
// +--------------------------------------------------------------------------+
// | tb_sevenseg_capture                                                      |
// | Scoreboarded random + directed bench for sevenseg_capture.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sevenseg_capture;

    localparam int NDIG = 4;
    localparam int S    = 4;

    typedef struct {
        int          cyc;
        int          kind;   // 1 = upd, 2 = err
        int          idx;
        logic [15:0] val;
        logic [3:0]  vld;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        upd;
    logic [7:0]  upd_idx;
    logic        err;

    sevenseg_capture #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .value       (value),
        .digit_valid (digit_valid),
        .upd         (upd),
        .upd_idx     (upd_idx),
        .err         (err)
    );

    always #5 clk = ~clk;

    int edge_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    logic [6:0]  tbl [16];
    logic [15:0] m_val;
    logic [3:0]  m_vld;
    logic [10:0] last;
    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;

    function automatic int lookup(input logic [6:0] seg);
        int r;
        r = -1;
        for (int j = 0; j < 16; j++) if (tbl[j] == seg) r = j;
        return r;
    endfunction

    task automatic drive_raw(input logic [6:0] seg, input logic [3:0] sel);
`ifdef SEVENSEG_CAPTURE_ACTIVE_LOW_EN
        seg_in  = ~seg;
        dig_sel = ~sel;
`else
        seg_in  = seg;
        dig_sel = sel;
`endif
    endtask

    // A held segment is accepted iff it lasts at least S sampling edges; the pulse
    // shows after edge (first edge + S).
    task automatic apply(input logic [6:0] seg, input logic [3:0] sel, input int n);
        exp_t e;
        int   idx;
        int   nib;
        e.cyc = edge_cnt + 1 + S;
        e.kind = 0;
        e.idx = 0;
        drive_raw(seg, sel);
        last = {seg, sel};
        if (n >= S && sel != 4'b0) begin
            if ($countones(sel) > 1) begin
                e.kind = 2;
            end else begin
                idx = 0;
                for (int i = 0; i < NDIG; i++) if (sel[i]) idx = i;
                nib = lookup(seg);
                if (seg == 7'h00) begin
                    m_vld[idx] = 1'b0;
                end else if (nib >= 0) begin
                    m_val[idx*4 +: 4] = nib[3:0];
                    m_vld[idx] = 1'b1;
                    e.kind = 1;
                    e.idx = idx;
                end else begin
                    e.kind = 2;
                end
            end
            e.val = m_val;
            e.vld = m_vld;
            if (e.kind != 0) q.push_back(e);
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string name);
        tests++;
        if (value !== m_val || digit_valid !== m_vld) begin
            fails++;
            $display("FAIL %s: value=%h valid=%b, expected value=%h valid=%b",
                     name, value, digit_valid, m_val, m_vld);
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    exp_t me;
    int   got_kind;
    always @(negedge clk) begin
        if (!reset) begin
            while (q.size() > 0 && q[0].cyc < edge_cnt) begin
                tests++;
                fails++;
                $display("FAIL missing_pulse: expected kind %0d at edge %0d did not occur",
                         q[0].kind, q[0].cyc);
                void'(q.pop_front());
            end
            if (upd || err) begin
                tests++;
                got_kind = (upd && err) ? 3 : (upd ? 1 : 2);
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse: kind %0d at edge %0d, expected none",
                             got_kind, edge_cnt);
                end else begin
                    me = q.pop_front();
                    if (got_kind != me.kind || edge_cnt != me.cyc ||
                        (upd && upd_idx != 8'(me.idx)) ||
                        value !== me.val || digit_valid !== me.vld) begin
                        fails++;
                        $display("FAIL pulse: kind %0d edge %0d idx %0d value %h valid %b, expected kind %0d edge %0d idx %0d value %h valid %b",
                                 got_kind, edge_cnt, upd_idx, value, digit_valid,
                                 me.kind, me.cyc, me.idx, me.val, me.vld);
                    end
                end
            end
        end
    end

    initial begin
        logic [6:0] rs;
        logic [3:0] rsel;
        int         r;
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        m_val = '0;
        m_vld = '0;
        last  = '0;
        drive_raw(7'h00, 4'b0000);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_state("reset_regs");
        check_eq("reset_pulses", {22'd0, upd, err, upd_idx}, 32'd0);
        reset = 1'b0;

        // First acceptance latency and digit 0 write
        apply(7'h5B, 4'b0001, 6);
        apply(7'h00, 4'b0000, 3);
        check_state("first_write");

        // Four-digit scan
        apply(7'h7F, 4'b0001, 6); apply(7'h00, 4'b0000, 2);
        apply(7'h06, 4'b0010, 6); apply(7'h00, 4'b0000, 2);
        apply(7'h77, 4'b0100, 6); apply(7'h00, 4'b0000, 2);
        apply(7'h39, 4'b1000, 6); apply(7'h00, 4'b0000, 4);
        check_eq("scan_value", {16'd0, value}, 32'h0000CA18);
        check_eq("scan_valid", {28'd0, digit_valid}, 32'hF);

        // Short glitch on digit 1, then a full hold on digit 2
        apply(7'h4F, 4'b0010, 3);
        apply(7'h4F, 4'b0100, 5);
        apply(7'h00, 4'b0000, 4);
        check_state("glitch");
        check_eq("glitch_nibble", {28'd0, value[11:8]}, 32'h3);

        // Illegal pattern and illegal select
        apply(7'h55, 4'b0001, 5); apply(7'h00, 4'b0000, 2);
        apply(7'h3F, 4'b0011, 5); apply(7'h00, 4'b0000, 4);
        check_state("illegal");

        // Random segments, including runs of exactly S-1 and S cycles
        for (int t = 0; t < 150; t++) begin
            do begin
                r = $urandom_range(0, 9);
                if (r < 2)       rsel = 4'b0000;
                else if (r == 2) begin
                    do rsel = 4'($urandom_range(0, 15)); while ($countones(rsel) < 2);
                end else         rsel = 4'b0001 << $urandom_range(0, 3);
                r = $urandom_range(0, 9);
                if (r == 0)      rs = 7'h00;
                else if (r == 1) begin
                    do rs = 7'($urandom_range(1, 127)); while (lookup(rs) >= 0);
                end else         rs = tbl[$urandom_range(0, 15)];
            end while ({rs, rsel} == last);
            apply(rs, rsel, $urandom_range(1, S + 2));
        end
        apply(7'h00, 4'b0000, S + 4);
        check_eq("queue_drained", 32'(q.size()), 32'd0);
        check_state("random_end");

        // Blank a digit, then reset in the middle of a count
        apply(7'h71, 4'b1000, 6);
        apply(7'h00, 4'b1000, 5);
        apply(7'h00, 4'b0000, 3);
        check_state("blank");
        check_eq("blank_nibble", {27'd0, value[15:12], digit_valid[3]}, {27'd0, 4'hF, 1'b0});
        apply(7'h06, 4'b0001, 2);
        #2 reset = 1'b1;
        #1;
        check_eq("async_reset", {3'd0, value, digit_valid, upd, upd_idx, err}, 32'd0);
        m_val = '0;
        m_vld = '0;
        q.delete();
        @(negedge clk);
        reset = 1'b0;

        // Exactly S-cycle hold after reset
        apply(7'h6D, 4'b0100, S);
        apply(7'h00, 4'b0000, 5);
        check_state("post_reset");
        check_eq("post_queue", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Receive-side counterpart to the team's hex-to-seven-segment decoder.
- Monitors a time-multiplexed 7-segment display bus (segment lines plus one-hot digit selects) and recovers the hex nibble shown on each digit.
- Debounces scan transitions, flags illegal patterns, and presents a per-digit value register.
- Used as a self-checking monitor on display outputs and as a loopback front end in lab test harnesses.

Parameters:
- NDIG, 4, number of multiplexed digits; one dig_sel bit per digit.
- STABLE_CYC, 4, consecutive clock cycles the registered {seg_in, dig_sel} must stay unchanged before acceptance; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment lines; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g; 1 = lit.
- dig_sel  input  NDIG  digit enables, active-high, expected one-hot.
- value  output  4*NDIG  decoded nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  output  NDIG  digit i holds a decoded, non-blank value.
- upd  output  1  one-cycle pulse when a digit is written.
- upd_idx  output  8  index of the digit written on upd; zero-extended.
- err  output  1  one-cycle pulse on an illegal pattern or illegal select.

Behaviour:
- Reset, asynchronous, active-high: value=0, digit_valid=0, upd=0, upd_idx=0, err=0, input register=0, counter=0, FSM=WAIT. Reset mid-run discards any partial count.
- Input stage: {seg_in, dig_sel} registered every rising edge into s_q.
  - If the new sample differs from s_q: counter clears to 0 and FSM goes to WAIT.
  - Otherwise the counter increments, saturating at 255.
- FSM, two states:
  - WAIT: when the counter reaches STABLE_CYC-1 with unchanged input, perform the acceptance action on the next edge and go to HELD.
  - HELD: no further action until s_q changes, then return to WAIT. Each stable run is accepted exactly once.
- Latency: inputs first sampled at edge k and held constant produce upd/err high during the cycle after edge k+STABLE_CYC, for exactly one cycle.
- Acceptance action on s_q:
  - dig_sel == 0 (inter-digit blanking): no effect, no pulse.
  - dig_sel with more than one bit set: err pulse; registers unchanged.
  - One-hot dig_sel, index i, seg_in == 7'h00 (blank digit): clear digit_valid[i]; value unchanged; no upd, no err.
  - One-hot dig_sel, index i, seg_in in the legal table: value[i] = nibble, digit_valid[i] = 1, upd = 1, upd_idx = i. A write of the same value still pulses upd.
  - Any other seg_in: err pulse; value and digit_valid unchanged.
- Legal table, seg hex (gfedcba) -> nibble: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F. Exact match only; no don't-care bits.
- upd and err are never both high in the same cycle.
- A change of inputs in the same cycle as an acceptance does not cancel that acceptance; the new sample starts a fresh count.
- STABLE_CYC=1: acceptance occurs on the edge after the first sample.

Optional Feature:
- Macro: SEVENSEG_CAPTURE_ACTIVE_LOW_EN.
- Defined: seg_in and dig_sel are active-low, for common-anode boards. Both are inverted before the input register; all table values and rules above apply to the inverted data. Reset value of the input register is all-ones on the raw side, which is 0 after inversion.
- Not defined: active-high, exactly as specified above.

Test Plan:
- Reset then hold seg_in=7'h5B, dig_sel=4'b0001, STABLE_CYC=4 from edge 0 -> upd high only in the cycle after edge 4; upd_idx=0; value[3:0]=2; digit_valid=4'b0001.
- Scan all four digits with 7F/06/77/39, each held 6 cycles with 2 blanking cycles between -> value=16'hCA18, digit_valid=4'hF, exactly 4 upd pulses, err never high.
- Glitch: hold 7'h4F on digit 1 for 3 cycles, then 7'h4F on digit 2 for 5 cycles -> no write to digit 1; value[11:8]=3; upd_idx=2.
- Illegal inputs: seg_in=7'h55 on digit 0, then dig_sel=4'b0011 with 7'h3F -> two err pulses; value and digit_valid unchanged.
- Blank: digit 3 holds 'F' (7'h71), then 7'h00 held 5 cycles -> digit_valid[3]=0, value[15:12] still F, no upd; then assert reset mid-count -> all outputs 0 immediately, before the next clock edge.
- With SEVENSEG_CAPTURE_ACTIVE_LOW_EN defined: seg_in=7'h40, dig_sel=4'b1110 -> value[3:0]=0, digit_valid[0]=1.
